// File: rtl/bram_pixel_source.sv
// Raster pixel source: reads 24-bit RGB from a 1-cycle-latency frame BRAM and streams
// pixels with valid/ready, sof/eol and a frame_done pulse, using a 2-entry skid buffer.
module bram_pixel_source #(
    parameter int H_RES  = 64,
    parameter int V_RES  = 48,
    parameter int ADDR_W = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              run,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [23:0]       bram_rdata,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              valid,
    input  logic              ready,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              frame_done
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        last;
        logic [23:0] rgb;
    } entry_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Sideband of the read currently in flight; it meets bram_rdata one cycle later.
    logic              pend_q, pend_d;
    logic              pend_sof_q, pend_sof_d;
    logic              pend_eol_q, pend_eol_d;
    logic              pend_last_q, pend_last_d;

    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    entry_t            mem_q [2];
    entry_t            mem_d [2];

    logic [1:0]        occ;
    logic              xfer;
    logic              issue;
    logic              x_last;
    logic              y_last;
    logic              frame_last;
    entry_t            head;

    always_comb begin
        occ        = count_q + 2'(pend_q);
        xfer       = (count_q != 2'd0) && ready;
        issue      = (state_q == ST_RUN) && ((occ < 2'd2) || xfer);
        x_last     = (x_q == X_W'(H_RES - 1));
        y_last     = (y_q == Y_W'(V_RES - 1));
        frame_last = x_last && y_last;
    end

    // Raster counters, in-flight tracking, buffer bookkeeping and FSM.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        pend_d      = issue;
        pend_sof_d  = (x_q == '0) && (y_q == '0);
        pend_eol_d  = x_last;
        pend_last_d = frame_last;
        count_d     = count_q + 2'(pend_q) - 2'(xfer);
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem_d       = mem_q;

        if (issue) begin
            if (x_last) begin
                x_d = '0;
                if (y_last) begin
                    y_d    = '0;
                    addr_d = '0;
                end else begin
                    y_d    = y_q + Y_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end else begin
                x_d    = x_q + X_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        if (pend_q) begin
            mem_d[wr_ptr_q] = '{sof: pend_sof_q, eol: pend_eol_q, last: pend_last_q, rgb: bram_rdata};
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // run is only consulted in IDLE and when the final pixel of a frame is issued.
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (issue && frame_last && !run) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (occ == 2'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_sof_q  <= 1'b0;
            pend_eol_q  <= 1'b0;
            pend_last_q <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_sof_q  <= pend_sof_d;
            pend_eol_q  <= pend_eol_d;
            pend_last_q <= pend_last_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
        end
    end

    // Head entry drives the stream; fields are masked so nothing leaks while empty.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        valid      = (count_q != 2'd0);
        r          = valid ? head.rgb[23:16] : 8'd0;
        g          = valid ? head.rgb[15:8]  : 8'd0;
        b          = valid ? head.rgb[7:0]   : 8'd0;
        sof        = valid && head.sof;
        eol        = valid && head.eol;
        frame_done = xfer && head.last;
        busy       = (state_q != ST_IDLE) || (count_q != 2'd0) || pend_q;
        bram_en    = issue;
        bram_addr  = addr_q;
    end

endmodule

// File: tb/tb_bram_pixel_source.sv
// Directed bench for bram_pixel_source on an 8x2 frame; a negedge monitor pops an
// expected-pixel scoreboard on every handshake and checks stall/credit properties.
module tb_bram_pixel_source;

    localparam int H    = 8;
    localparam int V    = 2;
    localparam int AW   = 4;
    localparam int NPIX = H * V;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        logic        fd;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          run;
    logic          ready;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [23:0]   bram_rdata;
    logic [7:0]    r, g, b;
    logic          valid, sof, eol, busy, frame_done;

    exp_t          sb[$];
    exp_t          e_mon;
    int            total = 0;
    int            bad   = 0;
    int            occ_m = 0;
    logic          mon_en     = 1'b0;
    logic          bubble_chk = 1'b0;
    logic          seen_first = 1'b0;
    logic          prev_hold  = 1'b0;
    logic [25:0]   prev_out   = '0;
    logic          xfer_s;

    bram_pixel_source #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .run        (run),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
        .r          (r),
        .g          (g),
        .b          (b),
        .valid      (valid),
        .ready      (ready),
        .sof        (sof),
        .eol        (eol),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 aclk = ~aclk;

    function automatic logic [23:0] bramWord(input int a);
        logic [7:0] a8;
        a8 = 8'(a);
        return {a8, a8 + 8'd1, a8 + 8'd2};
    endfunction

    // Preloaded frame memory with one cycle of read latency.
    always @(posedge aclk) begin
        if (bram_en) bram_rdata <= bramWord(int'(bram_addr));
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic run_v, input logic ready_v, input logic rstn_v);
        @(posedge aclk);
        #1;
        run     = run_v;
        ready   = ready_v;
        aresetn = rstn_v;
    endtask

    task automatic pushFrame();
        exp_t e;
        for (int a = 0; a < NPIX; a++) begin
            e.rgb = bramWord(a);
            e.sof = (a == 0);
            e.eol = ((a % H) == H - 1);
            e.fd  = (a == NPIX - 1);
            sb.push_back(e);
        end
    endtask

    task automatic waitIdle(input int max_cycles, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge aclk);
            #1;
            if (!busy && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    // Handshake monitor: scoreboard pops, hold-during-stall, bubbles and credit bound.
    always @(negedge aclk) begin
        if (mon_en) begin
            xfer_s = valid && ready;
            if (prev_hold && aresetn) begin
                checkOutput("hold_valid", 32'(valid), 32'd1);
                checkOutput("hold_data", 32'({r, g, b, sof, eol}), 32'(prev_out));
            end
            if (xfer_s) begin
                if (sb.size() == 0) begin
                    checkOutput("extra_xfer", 32'(sb.size()), 32'd1);
                end else begin
                    e_mon = sb.pop_front();
                    checkOutput("pixel", 32'({r, g, b, sof, eol, frame_done}),
                                32'({e_mon.rgb, e_mon.sof, e_mon.eol, e_mon.fd}));
                end
                seen_first = 1'b1;
            end else begin
                checkOutput("fd_no_xfer", 32'(frame_done), 32'd0);
                if (bubble_chk && seen_first && sb.size() > 0)
                    checkOutput("bubble", 32'(xfer_s), 32'd1);
            end
            if (!aresetn) begin
                occ_m = 0;
            end else begin
                if (occ_m == 2 && !xfer_s) checkOutput("en_at_full", 32'(bram_en), 32'd0);
                occ_m = occ_m + int'(bram_en) - int'(xfer_s);
                checkOutput("occ_max", 32'(occ_m <= 2), 32'd1);
            end
            prev_hold = valid && !ready && aresetn;
            prev_out  = {r, g, b, sof, eol};
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic found;
        logic done;

        aresetn = 1'b0;
        run     = 1'b0;
        ready   = 1'b0;

        $display("[TB] reset");
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_flags", 32'({valid, sof, eol, busy, bram_en, frame_done}), 32'd0);
        checkOutput("rst_rgb", 32'({r, g, b}), 32'd0);
        checkOutput("rst_addr", 32'(bram_addr), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        mon_en = 1'b1;

        $display("[TB] single frame, ready high");
        pushFrame();
        bubble_chk = 1'b1;
        seen_first = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t2_en_k", 32'(bram_en), 32'd1);
        checkOutput("t2_addr_k", 32'(bram_addr), 32'd0);
        checkOutput("t2_valid_k", 32'(valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t2_valid_k1", 32'(valid), 32'd0);
        checkOutput("t2_addr_k1", 32'(bram_addr), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t2_valid_k2", 32'(valid), 32'd1);
        checkOutput("t2_sof_k2", 32'(sof), 32'd1);
        waitIdle(60, "t2_idle");
        bubble_chk = 1'b0;

        $display("[TB] random backpressure");
        pushFrame();
        done = 1'b0;
        for (int c = 0; c < 800; c++) begin
            applyStimulus(c == 0, 1'($urandom_range(0, 1)), 1'b1);
            if (c > 2 && !busy && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("t3_done", 32'(done), 32'd1);

        $display("[TB] back-to-back frames");
        pushFrame();
        pushFrame();
        bubble_chk = 1'b1;
        seen_first = 1'b0;
        found = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 100; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (sb.size() <= 12) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t4_second_frame", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitIdle(80, "t4_idle");
        bubble_chk = 1'b0;

        $display("[TB] run dropped mid-frame");
        pushFrame();
        found = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (bram_en && bram_addr == AW'(3)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t5_addr3", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitIdle(60, "t5_idle");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("t5_no_read", 32'(bram_en), 32'd0);
        end

        $display("[TB] reset mid-frame");
        pushFrame();
        found = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (bram_en && bram_addr == AW'(5)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t6_addr5", 32'(found), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t6_valid", 32'(valid), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        sb.delete();
        pushFrame();
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t6_restart", 32'({bram_en, bram_addr}), 32'({1'b1, AW'(0)}));
        waitIdle(60, "t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
